// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with press/release
// debounce and a two-digit key history for the seven-segment display path.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   rows[3:0]  keypad row lines, active-low, asynchronous to clk
//   cols[3:0]  column drive, active-low, exactly one bit low
//   key[3:0]   hex code of the most recently accepted key
//   key_valid  one-cycle pulse when a new key is accepted
//   digit_new  most recent accepted key (right display digit)
//   digit_old  previously accepted key (left display digit)
module keypad_scanner #(
    parameter int SCAN_DIV        = 12000,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [3:0]       rows_meta;
    logic [3:0]       rs;

    logic [1:0]       col;
    logic [1:0]       col_nxt;
    logic [1:0]       row;
    logic [1:0]       row_nxt;
    logic [1:0]       low_row;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_nxt;

    logic [3:0]       cols_nxt;
    logic [3:0]       key_nxt;
    logic             key_valid_nxt;
    logic [3:0]       new_nxt;
    logic [3:0]       old_nxt;

    logic             row_up;
    logic [3:0]       map_code;

    // Keypad legend as hex codes, indexed by row then column.
    function automatic logic [3:0] key_map(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // Lowest-index active row wins when several rows are low together.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) begin
                low_row = 2'(i);
            end
        end
    end

    // Only the row latched at detection matters after SCAN.
    assign row_up   = rs[row];
    assign map_code = key_map(row, col);

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        row_nxt       = row;
        div_nxt       = div_cnt;
        deb_nxt       = deb_cnt;
        key_nxt       = key;
        key_valid_nxt = 1'b0;
        new_nxt       = digit_new;
        old_nxt       = digit_old;

        unique case (state)
            SCAN: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (rs != 4'hF) begin
                        row_nxt   = low_row;
                        deb_nxt   = '0;
                        state_nxt = DEBOUNCE;
                    end else begin
                        col_nxt = col + 2'd1;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (row_up) begin
                    state_nxt = SCAN;
                    col_nxt   = col + 2'd1;
                    div_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                    // Count reaches the threshold on this edge.
                    if (deb_cnt == DEB_LAST) begin
                        state_nxt     = HELD;
                        key_nxt       = map_code;
                        new_nxt       = map_code;
                        old_nxt       = digit_new;
                        key_valid_nxt = 1'b1;
                    end
                end
            end

            HELD: begin
                if (row_up) begin
                    deb_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end

            RELEASE: begin
                if (!row_up) begin
                    state_nxt = HELD;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                    if (deb_cnt == DEB_LAST) begin
                        state_nxt = SCAN;
                        col_nxt   = col + 2'd1;
                        div_nxt   = '0;
                    end
                end
            end

            default: begin
                state_nxt = SCAN;
            end
        endcase

        // Column drive is registered from the next column index.
        cols_nxt = ~(4'b0001 << col_nxt);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            rows_meta <= 4'h0;
            rs        <= 4'h0;
            col       <= 2'd0;
            row       <= 2'd0;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            cols      <= 4'b1110;
            key       <= 4'h0;
            key_valid <= 1'b0;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
        end else begin
            state     <= state_nxt;
            rows_meta <= rows;
            rs        <= rows_meta;
            col       <= col_nxt;
            row       <= row_nxt;
            div_cnt   <= div_nxt;
            deb_cnt   <= deb_nxt;
            cols      <= cols_nxt;
            key       <= key_nxt;
            key_valid <= key_valid_nxt;
            digit_new <= new_nxt;
            digit_old <= old_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a
// behavioral keypad model reacting to the column drive.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DB  = 8;
    localparam int LAT = SD + DB;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows  = 4'hF;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key      (key),
        .key_valid(key_valid),
        .digit_new(digit_new),
        .digit_old(digit_old)
    );

    typedef struct packed {
        logic [3:0] k;
        logic [3:0] dn;
        logic [3:0] dold;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int step_no  = 0;
    int last_chg = 0;

    logic [3:0] prev_cols = 4'hE;
    logic [3:0] m_new     = 4'h0;
    logic [3:0] m_old     = 4'h0;

    logic       press_on   = 1'b0;
    int         press_r    = 0;
    int         press_r2   = -1;
    int         press_c    = 0;
    logic       force_on   = 1'b0;
    logic [3:0] force_rows = 4'hF;

    logic [3:0] kmap [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_rows();
        logic [3:0] r;
        r = 4'hF;
        if (force_on) begin
            r = force_rows;
        end else if (press_on && !cols[press_c]) begin
            r[press_r] = 1'b0;
            if (press_r2 >= 0) r[press_r2] = 1'b0;
        end
        rows = r;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        step_no++;
        if (cols != prev_cols) begin
            last_chg  = step_no;
            prev_cols = cols;
        end
        if (key_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                check("kv_spurious", 32'(key_valid), 0);
            end else begin
                e = sb.pop_front();
                check("key", 32'(key), 32'(e.k));
                check("digit_new", 32'(digit_new), 32'(e.dn));
                check("digit_old", 32'(digit_old), 32'(e.dold));
                check("kv_latency", step_no - last_chg, LAT);
            end
        end
        drive_rows();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Wait for a fresh switch of the column drive to column c.
    task automatic wait_col(input int c);
        logic [3:0] want;
        logic       hit;
        want = ~(4'b0001 << c);
        hit  = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step();
            if (last_chg == step_no && cols == want) hit = 1'b1;
        end
        if (!hit) check("wait_col", 32'(cols), 32'(want));
    endtask

    task automatic wait_pulse(input int n0);
        for (int i = 0; i < 80 && pulses == n0; i++) step();
        if (pulses == n0) check("wait_pulse", pulses, n0 + 1);
    endtask

    // Start holding a key just as the preceding column is driven.
    task automatic press_key(input int r, input int c, input int r2);
        exp_t e;
        wait_col((c + 3) % 4);
        press_r  = r;
        press_c  = c;
        press_r2 = r2;
        press_on = 1'b1;
        e.k      = kmap[r][c];
        e.dn     = kmap[r][c];
        e.dold   = m_new;
        m_old    = m_new;
        m_new    = kmap[r][c];
        sb.push_back(e);
        drive_rows();
    endtask

    task automatic release_key();
        press_on = 1'b0;
        press_r2 = -1;
        drive_rows();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        // Reset and free-running column scan.
        reset = 1'b0;
        steps(3);
        check("rst_cols", 32'(cols), 32'hE);
        check("rst_key", 32'(key), 0);
        check("rst_dn", 32'(digit_new), 0);
        check("rst_do", 32'(digit_old), 0);
        check("rst_kv", 32'(key_valid), 0);
        reset = 1'b1;
        steps(4);
        check("scan_c1", 32'(cols), 32'hD);
        steps(4);
        check("scan_c2", 32'(cols), 32'hB);
        steps(4);
        check("scan_c3", 32'(cols), 32'h7);
        steps(4);
        check("scan_c0", 32'(cols), 32'hE);

        // Single press '5'.
        p0 = pulses;
        press_key(1, 1, -1);
        steps(60);
        check("held_cols", 32'(cols), 32'hD);
        check("p5_pulses", pulses - p0, 1);
        release_key();
        steps(10);
        check("rel_frozen", 32'(cols), 32'hD);
        steps(1);
        check("rel_adv", 32'(cols), 32'hB);
        check("key_hold5", 32'(key), 32'h5);

        // Second press '9' shifts the history.
        p0 = pulses;
        press_key(2, 2, -1);
        steps(40);
        check("p9_pulses", pulses - p0, 1);
        release_key();
        steps(15);

        // Bounce on press at row0/col3.
        p0 = pulses;
        wait_col(3);
        force_rows = 4'b1110;
        force_on   = 1'b1;
        drive_rows();
        steps(3);
        force_on = 1'b0;
        drive_rows();
        steps(1);
        check("bnc_freeze", 32'(cols), 32'h7);
        steps(1);
        check("bnc_freeze2", 32'(cols), 32'h7);
        steps(1);
        check("bnc_resume", 32'(cols), 32'hE);
        steps(20);
        check("bnc_pulses", pulses - p0, 0);

        // Bounce on release of '0'.
        p0 = pulses;
        press_key(3, 1, -1);
        wait_pulse(p0);
        steps(3);
        release_key();
        steps(4);
        press_on = 1'b1;
        drive_rows();
        steps(2);
        release_key();
        steps(10);
        check("rbnc_frozen", 32'(cols), 32'hD);
        steps(1);
        check("rbnc_adv", 32'(cols), 32'hB);
        steps(10);
        check("rbnc_pulses", pulses - p0, 1);
        check("rbnc_key", 32'(key), 32'h0);

        // Two rows low on col0: lowest row wins.
        p0 = pulses;
        press_key(0, 0, 2);
        steps(40);
        check("prio_pulses", pulses - p0, 1);
        check("prio_key", 32'(key), 32'h1);
        release_key();
        steps(15);

        // Reset during the 4th debounce cycle of 'D'.
        p0 = pulses;
        wait_col(2);
        press_r  = 3;
        press_c  = 3;
        press_r2 = -1;
        press_on = 1'b1;
        drive_rows();
        wait_col(3);
        steps(7);
        reset = 1'b0;
        steps(1);
        check("mrst_cols", 32'(cols), 32'hE);
        check("mrst_key", 32'(key), 0);
        check("mrst_dn", 32'(digit_new), 0);
        check("mrst_do", 32'(digit_old), 0);
        check("mrst_kv", 32'(key_valid), 0);
        m_new = 4'h0;
        m_old = 4'h0;
        release_key();
        steps(2);
        reset = 1'b1;
        steps(30);
        check("mrst_pulses", pulses - p0, 0);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad and debounces key presses. Accepted keys are shifted into a two-digit history whose outputs drive the existing two-digit time-multiplexed seven-segment display path. It is the input-side counterpart of the display multiplexer: it drives one column at a time and reads the rows, where the display block drives one digit enable at a time and presents data.

## Interface
- `SCAN_DIV`, 12000: clock cycles each column is driven before advancing (1 ms at 12 MHz).
- `DEBOUNCE_CYCLES`, 240000: consecutive stable cycles required to accept a press or a release (20 ms at 12 MHz).
- `clk`  in  1  system clock (12 MHz).
- `reset`  in  1  synchronous, active-low reset.
- `rows`  in  4  keypad row lines, active-low, externally pulled up, asynchronous to `clk`.
- `cols`  out  4  column drive, active-low, exactly one bit low at all times.
- `key`  out  4  hex code of the most recently accepted key.
- `key_valid`  out  1  one-cycle pulse when a new key is accepted.
- `digit_new`  out  4  most recent accepted key; feeds the right display digit.
- `digit_old`  out  4  previously accepted key; feeds the left display digit.

## Operation
- `rows` passes through a 2-flop synchronizer. All decisions use the synchronized value `rs`.
- Key map, indexed row r and column c, with labels as hex codes:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - Column counter c drives `cols` = ~(1<<c).
  - The divider counts 0..SCAN_DIV-1. On its last cycle, `rs` is sampled.
  - If any bit of `rs` is low, record c and the lowest-index low row r, clear the debounce counter, enter DEBOUNCE, and freeze c.
  - Otherwise c advances modulo 4 (3 wraps to 0).
- DEBOUNCE:
  - `cols` stays frozen.
  - Each cycle with `rs[r]` low increments the counter.
  - If `rs[r]` is high on any cycle, return to SCAN with c advanced by 1 and the divider cleared.
  - When the counter reaches DEBOUNCE_CYCLES:
    - Accept the key and enter HELD.
    - Load `key` with the map value.
    - Load `digit_old` ← `digit_new` and `digit_new` ← map value.
    - Pulse `key_valid`.
- HELD:
  - Stay while `rs[r]` is low. Other rows and columns are ignored.
  - When `rs[r]` goes high, clear the counter and enter RELEASE.
- RELEASE:
  - Each cycle with `rs[r]` high increments the counter.
  - If `rs[r]` is low on any cycle, return to HELD with no new key.
  - When the counter reaches DEBOUNCE_CYCLES, enter SCAN with c advanced by 1 and the divider cleared.
- Counter widths are $clog2(parameter+1). Counters never wrap inside a state.
- Reset values: state SCAN, c=0, `cols`=4'b1110, `key`=0, `key_valid`=0, `digit_new`=0, `digit_old`=0, all counters and synchronizer flops 0.
- A low `reset` sampled on any clock edge restores all reset values, in every state, including mid-debounce.

## Timing
- Synchronizer latency: a `rows` change is visible in `rs` 2 cycles later.
- Press to `key_valid`: a press recognised at the SCAN sample produces `key_valid` exactly DEBOUNCE_CYCLES cycles after DEBOUNCE entry, provided `rs[r]` stays low.
- `key_valid` is high for exactly 1 cycle per accepted press.
- `key`, `digit_new` and `digit_old` update on the same edge that raises `key_valid`, and hold their values until the next accepted press.
- `cols` changes only on SCAN advance, or on exit from DEBOUNCE or RELEASE. It is registered and glitch-free.
- One full scan takes 4*SCAN_DIV cycles. Worst-case detection delay for a stable press is 4*SCAN_DIV + 2 cycles.

## Test plan
All tests use `SCAN_DIV`=4 and `DEBOUNCE_CYCLES`=8.
- Reset: hold `reset` low for 3 cycles → `cols`=1110, `key`=0, `digit_new`=0, `digit_old`=0, `key_valid`=0; on release, `cols` steps 1110→1101→1011→0111→1110 every 4 cycles.
- Single press: hold `rows`[1] low whenever col1 is driven, for 60 cycles → exactly one `key_valid` pulse; `key`=5, `digit_new`=5, `digit_old`=0; `cols` stays 1101 until release completes.
- Second press: after releasing '5', press row2/col2 ('9') → `digit_new`=9, `digit_old`=5, with one pulse.
- Bounce on press: row0/col3 low for 3 cycles only → no `key_valid`; SCAN resumes at col0 (`cols`=1110).
- Bounce on release: hold '0' (row3/col1) until accepted, release, re-assert low for 2 cycles, then release for 10 cycles → exactly one pulse total, `key`=0.
- Priority and reset:
  - rows 0 and 2 low together on col0 → `key`=1.
  - Assert `reset` low at the 4th DEBOUNCE cycle of a new press → all outputs return to reset values and no `key_valid` occurs.
